// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports
// with same-cycle forwarding, busy scoreboard and a post-reset clear sweep.
// Ports: clock/reset, ready, rd_addr/rd_data/rd_busy, we/wa/wd x2,
//        iss_valid/iss_rd, busy_vec.
module reg_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 4
) (
  input  logic                clock,
  input  logic                reset,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy_vec
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic             r_ready;
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic w_wr0;
  logic w_wr1;
  logic w_iss;

  // Traffic is only honoured once the sweep is done; x0 is never written.
  assign w_wr0 = r_ready && we0 && (wa0 != '0);
  assign w_wr1 = r_ready && we1 && (wa1 != '0);
  assign w_iss = r_ready && iss_valid && (iss_rd != '0);

  assign ready    = r_ready;
  assign busy_vec = r_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CLEAR;
      r_idx   <= '0;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == AW'(NREGS - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // Storage: sweep clears one entry per cycle; port 1 is written last so
  // it wins on an address collision.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_regs[r_idx] <= '0;
      end else begin
        if (w_wr0) r_regs[wa0] <= wd0;
        if (w_wr1) r_regs[wa1] <= wd1;
      end
    end
  end

  // Scoreboard: a new issue beats a retiring write to the same register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_iss && (iss_rd == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((w_wr0 && (wa0 == AW'(i))) ||
                     (w_wr1 && (wa1 == AW'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_h0;
    logic          w_h1;

    assign w_a  = rd_addr[k*AW +: AW];
    assign w_h0 = w_wr0 && (wa0 == w_a);
    assign w_h1 = w_wr1 && (wa1 == w_a);

    assign rd_data[k*XLEN +: XLEN] =
      (!r_ready || (w_a == '0)) ? '0 :
      w_h1                      ? wd1 :
      w_h0                      ? wd0 :
                                  r_regs[w_a];

    // A same-cycle write supplies the value, so the register is not busy.
    assign rd_busy[k] = !r_ready ||
                        (r_busy[w_a] && !w_h0 && !w_h1);
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed steps plus random traffic
// checked against an array-based reference model.
module tb_reg_file_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 4;

  logic                clock;
  logic                reset;
  logic                ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NREGS-1:0]    busy_vec;

  reg_file_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)
  ) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy_vec(busy_vec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];
  bit              m_ready;
  int              m_cnt;

  task automatic chk(input string tag,
                     input logic [127:0] o,
                     input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic set_port(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  // Compare all outputs with the model mid-cycle, then clock once and
  // advance the model with the inputs that were present at the edge.
  task automatic cyc(input string tag);
    logic [127:0]     ed;
    logic [3:0]       eb;
    logic [31:0]      ev;
    logic [AW-1:0]    a;
    int               ai;
    #2;
    ed = '0;
    eb = '0;
    for (int k = 0; k < NRD; k++) begin
      a  = rd_addr[k*AW +: AW];
      ai = int'(a);
      if (!m_ready) begin
        ed[k*XLEN +: XLEN] = '0;
        eb[k] = 1'b1;
      end else if (ai == 0) begin
        ed[k*XLEN +: XLEN] = '0;
        eb[k] = 1'b0;
      end else if (we1 && wa1 == a) begin
        ed[k*XLEN +: XLEN] = wd1;
        eb[k] = 1'b0;
      end else if (we0 && wa0 == a) begin
        ed[k*XLEN +: XLEN] = wd0;
        eb[k] = 1'b0;
      end else begin
        ed[k*XLEN +: XLEN] = m_mem[ai];
        eb[k] = m_busy[ai];
      end
    end
    for (int i = 0; i < NREGS; i++) ev[i] = m_busy[i];
    chk({tag, "_rd_data"}, 128'(rd_data), ed);
    chk({tag, "_rd_busy"}, 128'(rd_busy), 128'(eb));
    chk({tag, "_ready"}, 128'(ready), 128'(m_ready));
    chk({tag, "_busy_vec"}, 128'(busy_vec), 128'(ev));
    @(posedge clock);
    if (reset) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NREGS) begin
        m_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
      end
    end else begin
      if (we0 && wa0 != 0) m_mem[int'(wa0)] = wd0;
      if (we1 && wa1 != 0) m_mem[int'(wa1)] = wd1;
      for (int i = 1; i < NREGS; i++) begin
        if (iss_valid && int'(iss_rd) == i)
          m_busy[i] = 1'b1;
        else if ((we0 && int'(wa0) == i) || (we1 && int'(wa1) == i))
          m_busy[i] = 1'b0;
      end
    end
    #1;
  endtask

  int n;

  initial begin
    reset = 1'b1;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clock);
    m_ready = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < NREGS; i++) begin
      m_busy[i] = 1'b0;
      m_mem[i]  = '0;
    end
    #1;
    reset = 1'b0;

    // Clear sweep; a write and an issue during it are discarded.
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      idle();
      for (int k = 0; k < NRD; k++) set_port(k, AW'($urandom));
      if (n == 10) begin
        we0 = 1'b1; wa0 = 5; wd0 = 32'h12345678;
        iss_valid = 1'b1; iss_rd = 6;
        #2;
        chk("sweep_busy", 128'(rd_busy), 128'(4'hF));
        chk("sweep_data", 128'(rd_data), 128'(0));
      end
      cyc("sweep");
      n++;
    end
    chk("ready_at_32", 128'(n), 128'(32));

    idle();
    set_port(0, 5);
    #2;
    chk("x5_lost", 128'(rd_data[31:0]), 128'(0));
    cyc("x5");

    // Forwarding then storage of x3.
    we0 = 1'b1; wa0 = 3; wd0 = 32'hDEADBEEF;
    set_port(0, 3);
    #2;
    chk("fwd_x3", 128'(rd_data[31:0]), 128'(32'hDEADBEEF));
    cyc("fwd3");
    idle();
    #2;
    chk("stored_x3", 128'(rd_data[31:0]), 128'(32'hDEADBEEF));
    cyc("st3");

    // Same-address writes: port 1 wins.
    we0 = 1'b1; wa0 = 7; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 7; wd1 = 32'h22222222;
    set_port(2, 7);
    #2;
    chk("coll_fwd_x7", 128'(rd_data[95:64]), 128'(32'h22222222));
    cyc("coll7");
    idle();
    #2;
    chk("coll_st_x7", 128'(rd_data[95:64]), 128'(32'h22222222));
    cyc("st7");

    // x0 writes and issue to x0.
    we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFFFFFF;
    we1 = 1'b1; wa1 = 0; wd1 = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_rd = 0;
    set_port(0, 0);
    #2;
    chk("x0_fwd", 128'(rd_data[31:0]), 128'(0));
    cyc("x0w");
    idle();
    #2;
    chk("x0_busy", 128'(busy_vec[0]), 128'(0));
    chk("x0_st", 128'(rd_data[31:0]), 128'(0));
    cyc("x0r");

    // Scoreboard on x9.
    iss_valid = 1'b1; iss_rd = 9;
    set_port(1, 9);
    cyc("iss9");
    idle();
    #2;
    chk("bv9_set", 128'(busy_vec[9]), 128'(1));
    chk("rdb9_set", 128'(rd_busy[1]), 128'(1));
    cyc("hold9");
    we1 = 1'b1; wa1 = 9; wd1 = 32'hA5A5A5A5;
    #2;
    chk("rdb9_fwd", 128'(rd_busy[1]), 128'(0));
    chk("rdd9_fwd", 128'(rd_data[63:32]), 128'(32'hA5A5A5A5));
    cyc("wb9");
    idle();
    #2;
    chk("bv9_clr", 128'(busy_vec[9]), 128'(0));
    cyc("clr9");
    iss_valid = 1'b1; iss_rd = 9;
    cyc("iss9b");
    iss_valid = 1'b1; iss_rd = 9;
    we0 = 1'b1; wa0 = 9; wd0 = 32'h5A5A5A5A;
    cyc("isswb9");
    idle();
    #2;
    chk("bv9_stay", 128'(busy_vec[9]), 128'(1));
    cyc("stay9");

    // Random traffic with occasional reset.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      we0 = $urandom_range(0, 1) == 1;
      wa0 = AW'($urandom);
      wd0 = $urandom;
      we1 = $urandom_range(0, 1) == 1;
      wa1 = ($urandom_range(0, 5) == 0) ? wa0 : AW'($urandom);
      wd1 = $urandom;
      iss_valid = $urandom_range(0, 2) == 0;
      iss_rd = ($urandom_range(0, 4) == 0) ? wa1 : AW'($urandom);
      for (int k = 0; k < NRD; k++) begin
        case ($urandom_range(0, 3))
          0: set_port(k, wa0);
          1: set_port(k, wa1);
          default: set_port(k, AW'($urandom));
        endcase
      end
      cyc("rnd");
    end
    reset = 1'b0;
    idle();

    // Reach RUN, write x12, then reset and abort a sweep at index 15.
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      cyc("wait");
      n++;
    end
    we0 = 1'b1; wa0 = 12; wd0 = 32'hCAFEF00D;
    cyc("w12");
    idle();
    reset = 1'b1;
    cyc("rst1");
    reset = 1'b0;
    for (int c = 0; c < 15; c++) cyc("part");
    reset = 1'b1;
    cyc("rst2");
    reset = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      cyc("resweep");
      n++;
    end
    chk("ready_after_restart", 128'(n), 128'(32));
    set_port(3, 12);
    #2;
    chk("x12_cleared", 128'(rd_data[127:96]), 128'(0));
    cyc("fin");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
